inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Front stage of the single-issue MIPS core. Sits directly upstream of the control unit.
- Holds the PC and fetches 32-bit instructions over a request/ready handshake from instruction memory.
- Presents one instruction at a time to decode (inst, opcode, func) and waits for decode to accept it.
- On accept, applies redirects (branch/jump/jump-register) and halt requests that decode raises for the presented instruction.

Parameters:
- ADDR_W, 32, width of the PC and instruction-memory address.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned fetch address; stable while imem_req=1.
- imem_ready  in  1  memory returns data this cycle; meaningful only when imem_req=1.
- imem_rdata  in  INST_W  instruction data, valid with imem_ready.
- inst  out  INST_W  registered instruction presented to decode.
- opcode  out  6  inst[31:26].
- func  out  6  inst[5:0].
- inst_valid  out  1  inst/pc hold a valid instruction.
- inst_ack  in  1  decode consumes the presented instruction this cycle.
- redirect  in  1  taken branch/jump for the presented instruction; sampled only with inst_ack.
- redirect_target  in  ADDR_W  next PC when redirect=1.
- halted  in  1  syscall/halt decoded for the presented instruction; sampled only with inst_ack.
- pc  out  ADDR_W  address of the presented instruction.
- pc_plus4  out  ADDR_W  pc+4, for the link path.
- fetch_halted  out  1  fetch stopped permanently until reset.
- inst_count  out  32  number of instructions acknowledged.

Behaviour:
- Reset (rst=1 at an edge) forces all outputs and state to these values, regardless of current state:
  - state=WAIT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=0, inst_valid=0, fetch_halted=0, inst_count=0.
  - An outstanding memory request is abandoned. Memory must tolerate imem_req dropping.
- States are WAIT, HOLD and HALT.
- WAIT:
  - imem_req=1 and imem_addr=pc, held constant, from the first cycle after reset or redirect until imem_ready.
  - Cycle with imem_req=1 and imem_ready=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, go to HOLD.
  - Latency: data accepted at edge N, inst_valid high from cycle N+1.
- HOLD:
  - inst, pc and inst_valid stay stable until inst_ack=1.
  - At the ack edge, inst_count<=inst_count+1 (wraps at 2^32).
  - If halted=1: inst_valid<=0, fetch_halted<=1, imem_req stays 0, go to HALT. Halt takes priority over redirect.
  - Else if redirect=1: pc<=redirect_target with bits [1:0] forced to 00.
  - Else: pc<=pc+4, mod 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
  - In both non-halt cases: inst_valid<=0, imem_req<=1, imem_addr<=new pc, go to WAIT. The next request is visible the cycle after the ack.
- HALT: absorbing. imem_req=0, inst_valid=0, fetch_halted=1, inst_ack/redirect/halted ignored. Only rst leaves HALT.
- inst_ack while inst_valid=0: ignored, no count change (simulation assertion flags it).
- redirect or halted without inst_ack: ignored.
- imem_ready while imem_req=0: ignored.
- Back-to-back throughput: at most one instruction per 2 cycles (ready edge, then ack edge).
- opcode, func and pc_plus4 are combinational from registered inst/pc.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum {WAIT, HOLD, HALT};
  - opcode/func field positions;
  - RTYPE, SYSCALL and ADD constants (also used by decode);
  - the default RESET_PC value.
- One sub-module, pc_next: combinational next-PC select (halt hold, redirect target with alignment masking, pc+4 with wrap). The FSM and registers stay in inst_fetch_unit.

Test Plan:
- Reset with imem_ready=1 always and inst_ack asserted in each HOLD cycle -> imem_addr sequence 0x0, 0x4, 0x8. inst_valid alternates one cycle high per fetch. inst_count=3 after three acks.
- Memory delays imem_ready 3 cycles at addr 0x4 -> imem_addr held at 0x4 and imem_req held high for all 4 cycles. inst updated only after ready.
- Ack with redirect=1, redirect_target=0x0000_0103 -> next imem_addr=0x0000_0100. pc_plus4 of the presented instruction=pc+4.
- Present inst {RTYPE, func=SYSCALL} with halted=1 and redirect=1 on ack -> fetch_halted=1 the next cycle. imem_req stays 0 and further acks are ignored. inst_count increments once.
- RESET_PC=32'hFFFF_FFFC, ack without redirect -> next imem_addr=0x0000_0000.
- Assert rst during WAIT with imem_req=1 -> imem_req=0 after the reset edge. Refetch from RESET_PC once rst drops. inst_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end and decode: fetch FSM states,
// instruction field positions and the opcode/func constants both stages use.
package cpu_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  localparam logic [5:0] RTYPE   = 6'h00;
  localparam logic [5:0] SYSCALL = 6'h0c;
  localparam logic [5:0] ADD     = 6'h20;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_syscall(input logic [31:0] word);
    return (word[OPCODE_MSB:OPCODE_LSB] == RTYPE) &&
           (word[FUNC_MSB:FUNC_LSB] == SYSCALL);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC select for the fetch stage: hold on halt, aligned redirect target,
// otherwise sequential pc+4 wrapping modulo 2^ADDR_W.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    pc_plus4 = pc + ADDR_W'(4);
    if (halt) begin
      next_pc = pc;
    end else if (redirect) begin
      next_pc = redirect_target & ~ADDR_W'(3);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: requests the word at pc, holds it for decode until acknowledged,
// then steps, redirects or halts according to what decode reports.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic              inst_valid,
  input  logic              inst_ack,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_halted,
  output logic [31:0]       inst_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fetch_halted_q, fetch_halted_d;
  logic [31:0]       inst_count_q, inst_count_d;
  logic [ADDR_W-1:0] next_pc;

  pc_next #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .pc              (pc_q),
    .halt            (halted),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    imem_req_d     = imem_req_q;
    imem_addr_d    = imem_addr_q;
    inst_d         = inst_q;
    inst_valid_d   = inst_valid_q;
    fetch_halted_d = fetch_halted_q;
    inst_count_d   = inst_count_q;

    unique case (state_q)
      WAIT: begin
        // Request is raised one cycle after reset/redirect, so ready is only
        // honoured once imem_req is actually visible to memory.
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
        if (imem_req_q && imem_ready) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (inst_ack) begin
          inst_count_d = inst_count_q + 32'd1;
          inst_valid_d = 1'b0;
          pc_d         = next_pc;
          if (halted) begin
            fetch_halted_d = 1'b1;
            imem_req_d     = 1'b0;
            state_d        = HALT;
          end else begin
            imem_req_d  = 1'b1;
            imem_addr_d = next_pc;
            state_d     = WAIT;
          end
        end
      end
      HALT: begin
        imem_req_d     = 1'b0;
        inst_valid_d   = 1'b0;
        fetch_halted_d = 1'b1;
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT;
      pc_q           <= RESET_PC;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= RESET_PC;
      inst_q         <= '0;
      inst_valid_q   <= 1'b0;
      fetch_halted_q <= 1'b0;
      inst_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      imem_req_q     <= imem_req_d;
      imem_addr_q    <= imem_addr_d;
      inst_q         <= inst_d;
      inst_valid_q   <= inst_valid_d;
      fetch_halted_q <= fetch_halted_d;
      inst_count_q   <= inst_count_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign inst         = inst_q;
  assign opcode       = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign func         = inst_q[FUNC_MSB:FUNC_LSB];
  assign inst_valid   = inst_valid_q;
  assign pc           = pc_q;
  assign fetch_halted = fetch_halted_q;
  assign inst_count   = inst_count_q;

  // Acks are legal only against a presented instruction; HALT ignores them.
  ack_without_valid: assert property (@(posedge clk) disable iff (rst)
    !(inst_ack && !inst_valid_q && state_q != HALT));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table for the main fetch sequence,
// plus a hand sequence for a second instance whose reset PC wraps.
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic        rst, imem_req, imem_ready, inst_valid, inst_ack, redirect, halted, fetch_halted;
  logic [31:0] imem_addr, imem_rdata, inst, redirect_target, pc, pc_plus4, inst_count;
  logic [5:0]  opcode, func;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk), .rst (rst), .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ready (imem_ready), .imem_rdata (imem_rdata), .inst (inst),
    .opcode (opcode), .func (func), .inst_valid (inst_valid), .inst_ack (inst_ack),
    .redirect (redirect), .redirect_target (redirect_target), .halted (halted),
    .pc (pc), .pc_plus4 (pc_plus4), .fetch_halted (fetch_halted), .inst_count (inst_count)
  );

  // Memory image: 0x4 holds an R-type ADD, 0x100 holds SYSCALL, others tagged by address.
  always_comb begin
    if (imem_addr == 32'h0000_0004)      imem_rdata = {RTYPE, 20'h0, ADD};
    else if (imem_addr == 32'h0000_0100) imem_rdata = {RTYPE, 20'h0, SYSCALL};
    else                                 imem_rdata = 32'h1000_0000 | imem_addr;
  end

  // ---------------- wrap DUT (RESET_PC = 0xFFFF_FFFC) ----------------
  logic        rst2, req2, ready2, valid2, ack2, fh2;
  logic [31:0] addr2, rdata2, inst2, pc2, pc4_2, cnt2;
  logic [5:0]  opc2, fn2;
  assign rdata2 = 32'hDEAD_BEEF;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk (clk), .rst (rst2), .imem_req (req2), .imem_addr (addr2),
    .imem_ready (ready2), .imem_rdata (rdata2), .inst (inst2),
    .opcode (opc2), .func (fn2), .inst_valid (valid2), .inst_ack (ack2),
    .redirect (1'b0), .redirect_target (32'h0), .halted (1'b0),
    .pc (pc2), .pc_plus4 (pc4_2), .fetch_halted (fh2), .inst_count (cnt2)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ready, ack, redir, halt;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
    logic        e_fhalt;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, rd, a, rdr, h, input logic [31:0] tgt,
                              input logic q, input logic [31:0] ad, input logic v,
                              input logic [31:0] in, p, input logic fh, input logic [31:0] c);
    vec_t x;
    x.rst = r; x.ready = rd; x.ack = a; x.redir = rdr; x.halt = h; x.target = tgt;
    x.e_req = q; x.e_addr = ad; x.e_valid = v; x.e_inst = in; x.e_pc = p;
    x.e_fhalt = fh; x.e_count = c;
    return x;
  endfunction

  initial begin
    logic [31:0] ei;
    bit          seen;

    rst = 1'b1; imem_ready = 1'b0; inst_ack = 1'b0; redirect = 1'b0; halted = 1'b0;
    redirect_target = '0;
    rst2 = 1'b1; ready2 = 1'b0; ack2 = 1'b0;

    //             rst rdy ack rdr hlt target        req addr          val inst          pc            fh cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // req rises, ready ignored
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'h1000_0000, 32'h0,       0, 0)); // accept @0
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h1000_0000, 32'h4,       0, 1)); // ack -> 4
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h1000_0000, 32'h4,       0, 1)); // stall 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h1000_0000, 32'h4,       0, 1)); // stall 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h1000_0000, 32'h4,       0, 1)); // stall 3
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0000_0020, 32'h4,       0, 1)); // accept ADD
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h0000_0020, 32'h8,       0, 2)); // ack -> 8
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h1000_0008, 32'h8,       0, 2)); // accept @8
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h200,       0, 32'h0000_0008, 1, 32'h1000_0008, 32'h8,       0, 2)); // redir/halt w/o ack ignored
    vecs.push_back(mk(0, 1, 1, 1, 0, 32'h103,       1, 32'h0000_0100, 0, 32'h1000_0008, 32'h100,     0, 3)); // redirect aligned
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0000_0100, 1, 32'h0000_000C, 32'h100,     0, 3)); // accept SYSCALL
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h300,       0, 32'h0000_0100, 0, 32'h0000_000C, 32'h100,     1, 4)); // halt beats redirect
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h0000_000C, 32'h100,     1, 4)); // ack in HALT ignored
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h40,        0, 32'h0000_0100, 0, 32'h0000_000C, 32'h100,     1, 4)); // still halted
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // reset leaves HALT
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // WAIT req high
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // reset abandons req
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0)); // refetch req
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'h1000_0000, 32'h0,       0, 0)); // refetch data

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; imem_ready = vecs[i].ready; inst_ack = vecs[i].ack;
      redirect = vecs[i].redir; halted = vecs[i].halt; redirect_target = vecs[i].target;
      @(posedge clk); #1;
      ei = vecs[i].e_inst;
      check($sformatf("v%0d imem_req", i),     {31'b0, imem_req},     {31'b0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i),    imem_addr,             vecs[i].e_addr);
      check($sformatf("v%0d inst_valid", i),   {31'b0, inst_valid},   {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d inst", i),         inst,                  ei);
      check($sformatf("v%0d opcode", i),       {26'b0, opcode},       {26'b0, ei[31:26]});
      check($sformatf("v%0d func", i),         {26'b0, func},         {26'b0, ei[5:0]});
      check($sformatf("v%0d pc", i),           pc,                    vecs[i].e_pc);
      check($sformatf("v%0d pc_plus4", i),     pc_plus4,              vecs[i].e_pc + 32'd4);
      check($sformatf("v%0d fetch_halted", i), {31'b0, fetch_halted}, {31'b0, vecs[i].e_fhalt});
      check($sformatf("v%0d inst_count", i),   inst_count,            vecs[i].e_count);
    end
    rst = 1'b1; imem_ready = 1'b0; inst_ack = 1'b0; redirect = 1'b0; halted = 1'b0;

    // Wrap instance: fetch at 0xFFFF_FFFC, sequential ack wraps to 0.
    @(posedge clk); #1;
    check("wrap reset addr", addr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (req2) seen = 1'b1;
    end
    check("wrap req timeout", {31'b0, seen}, 32'd1);
    ready2 = 1'b1;
    @(posedge clk); #1;
    ready2 = 1'b0;
    check("wrap valid", {31'b0, valid2}, 32'd1);
    check("wrap inst", inst2, 32'hDEAD_BEEF);
    check("wrap pc", pc2, 32'hFFFF_FFFC);
    check("wrap pc_plus4", pc4_2, 32'h0000_0000);
    ack2 = 1'b1;
    @(posedge clk); #1;
    ack2 = 1'b0;
    check("wrap next addr", addr2, 32'h0000_0000);
    check("wrap next req", {31'b0, req2}, 32'd1);
    check("wrap count", cnt2, 32'd1);
    check("wrap halted", {31'b0, fh2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
